// File: rtl/osd_wrvec_sink.sv
// OSD write-vector sink: resynchronises the NIOS PIO write vector into VCLK,
// turns each stable ctrl pulse into one write command, and executes it into
// the OSD char/colour RAMs while giving the renderer read port priority.
module osd_wrvec_sink #(
  parameter int unsigned STABLE_CYC = 3,
  parameter logic [6:0]  CLR_CHAR   = 7'h00
) (
  input  logic        VCLK,
  input  logic        nVRST,
  input  logic [24:0] OSDWrVector,
  input  logic        rd_en,
  input  logic [9:0]  rd_addr,
  output logic [6:0]  rd_char,
  output logic [3:0]  rd_color,
  output logic        rd_valid,
  output logic        clr_busy,
  output logic        wr_pending,
  output logic        wr_overrun
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [3:0] STAB_LAST = 4'(STABLE_CYC - 1);

  logic [24:0] sync1, sync2, prev;
  logic [3:0]  stab_cnt;
  logic        armed;
  logic        cmd_acc;

  state_t      state;
  logic [9:0]  clr_ptr;
  logic [3:0]  clr_color;
  logic [9:0]  pend_addr;
  logic        pend_is_char;
  logic [6:0]  pend_char;
  logic [3:0]  pend_color;

  logic        we_char, we_color;
  logic [9:0]  wa;
  logic [6:0]  wd_char;
  logic [3:0]  wd_color;

  logic [6:0]  char_mem  [1024];
  logic [3:0]  color_mem [1024];
  logic [6:0]  ram_char_q;
  logic [3:0]  ram_color_q;
  logic        rd_en_d;

  // prev holds the vector under observation; stab_cnt = (times seen) - 1,
  // so reaching STAB_LAST means STABLE_CYC identical samples.
  assign cmd_acc = armed && (prev[24:23] != 2'b00) && (stab_cnt == STAB_LAST);

  // Two-flop synchroniser, stability counter and one-shot arming
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      stab_cnt <= '0;
      armed    <= 1'b1;
    end else begin
      sync1 <= OSDWrVector;
      sync2 <= sync1;
      if (sync2 != prev) begin
        prev     <= sync2;
        stab_cnt <= '0;
      end else if (stab_cnt != 4'hF) begin
        stab_cnt <= stab_cnt + 4'd1;
      end
      if (cmd_acc)
        armed <= 1'b0;
      else if ((prev[24:23] == 2'b00) && (stab_cnt >= STAB_LAST))
        armed <= 1'b1;
    end
  end

  // RAM write port select: pending write in IDLE, clear sweep in CLEAR, never while reading
  always_comb begin
    we_char  = 1'b0;
    we_color = 1'b0;
    wa       = pend_addr;
    wd_char  = pend_char;
    wd_color = pend_color;
    case (state)
      IDLE: begin
        if (wr_pending && !rd_en) begin
          we_char  = pend_is_char;
          we_color = !pend_is_char;
        end
      end
      CLEAR: begin
        if (!rd_en) begin
          we_char  = 1'b1;
          we_color = 1'b1;
          wa       = clr_ptr;
          wd_char  = CLR_CHAR;
          wd_color = clr_color;
        end
      end
      default: ;
    endcase
  end

  // Command FSM: pending register, clear sweep and overrun flag
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      state        <= IDLE;
      clr_ptr      <= '0;
      clr_color    <= '0;
      clr_busy     <= 1'b0;
      wr_pending   <= 1'b0;
      wr_overrun   <= 1'b0;
      pend_addr    <= '0;
      pend_is_char <= 1'b0;
      pend_char    <= '0;
      pend_color   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_pending && !rd_en)
            wr_pending <= 1'b0;
        end
        CLEAR: begin
          if (!rd_en) begin
            if (clr_ptr == '1) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
            end else begin
              clr_ptr <= clr_ptr + 10'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // New command overrides the sweep bookkeeping above when it restarts a clear
      if (cmd_acc) begin
        if (wr_pending) begin
          wr_overrun <= 1'b1;
        end else if (prev[24:23] == 2'b11) begin
          state     <= CLEAR;
          clr_busy  <= 1'b1;
          clr_ptr   <= '0;
          clr_color <= prev[10:7];
        end else begin
          wr_pending   <= 1'b1;
          pend_addr    <= prev[22:13];
          pend_is_char <= (prev[24:23] == 2'b01);
          pend_char    <= prev[6:0];
          pend_color   <= prev[10:7];
        end
      end
    end
  end

  // Char/colour RAMs with separate write enables and registered read data
  always_ff @(posedge VCLK) begin
    if (we_char)
      char_mem[wa] <= wd_char;
    if (we_color)
      color_mem[wa] <= wd_color;
    if (rd_en) begin
      ram_char_q  <= char_mem[rd_addr];
      ram_color_q <= color_mem[rd_addr];
    end
  end

  // Read output register: data and valid two cycles after rd_en
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      rd_en_d  <= 1'b0;
      rd_valid <= 1'b0;
      rd_char  <= '0;
      rd_color <= '0;
    end else begin
      rd_en_d  <= rd_en;
      rd_valid <= rd_en_d;
      if (rd_en_d) begin
        rd_char  <= ram_char_q;
        rd_color <= ram_color_q;
      end
    end
  end

endmodule
